// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

   localparam int unsigned OVERSAMPLING = 16;
   localparam int unsigned START_MID    = 7;
   localparam int unsigned STOP_MID     = 15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   // Clocks per oversampling tick, truncated.
   function automatic int unsigned calc_div(input int unsigned clock_rate,
                                            input int unsigned baud_rate);
      return clock_rate / (baud_rate * OVERSAMPLING);
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running divider producing a one-cycle enable at 16x the baud rate.
module uart_rx_tick_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_RATE = 100_000_000,
   parameter int unsigned BAUD_RATE  = 9600
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned DIV = calc_div(CLOCK_RATE, BAUD_RATE);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (tick)
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampling with start-glitch rejection.
// UART_RX_PARITY_EN enables an even-parity bit before the stop bit.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned CLOCK_RATE = 100_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic                 tick;
   logic                 rx_meta, rx_sync;
   state_t               state, state_nx;
   logic [3:0]           s, s_nx;
   logic [NW-1:0]        n, n_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx;
   logic [DATA_BITS-1:0] data_nx;
   logic                 valid_nx, ferr_nx;
   logic                 brk, brk_nx;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit, par_nx;
   logic                 perr_q, perr_nx;
`endif

   uart_rx_tick_gen #(
      .CLOCK_RATE(CLOCK_RATE),
      .BAUD_RATE (BAUD_RATE)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   // Synchronizer resets high so reset release never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         s         <= '0;
         n         <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         brk       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         s         <= s_nx;
         n         <= n_nx;
         shreg     <= shreg_nx;
         rx_data   <= data_nx;
         rx_valid  <= valid_nx;
         frame_err <= ferr_nx;
         brk       <= brk_nx;
`ifdef UART_RX_PARITY_EN
         par_bit   <= par_nx;
         perr_q    <= perr_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      n_nx     = n;
      shreg_nx = shreg;
      data_nx  = rx_data;
      valid_nx = 1'b0;
      ferr_nx  = 1'b0;
      brk_nx   = brk;
`ifdef UART_RX_PARITY_EN
      par_nx   = par_bit;
      perr_nx  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_sync) begin
               state_nx = START;
               s_nx     = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s == 4'(START_MID)) begin
                  if (!rx_sync) begin
                     state_nx = DATA;
                     s_nx     = '0;
                     n_nx     = '0;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  s_nx = s + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s == 4'(STOP_MID)) begin
                  shreg_nx = {rx_sync, shreg[DATA_BITS-1:1]};
                  s_nx     = '0;
                  if (n == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_nx = PARITY;
`else
                     state_nx = STOP;
`endif
                  end else begin
                     n_nx = n + NW'(1);
                  end
               end else begin
                  s_nx = s + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (s == 4'(STOP_MID)) begin
                  par_nx   = rx_sync;
                  s_nx     = '0;
                  state_nx = STOP;
               end else begin
                  s_nx = s + 4'd1;
               end
            end
         end
`endif
         STOP: begin
            // brk marks a reported framing error; wait for line release only.
            if (brk) begin
               if (rx_sync) begin
                  brk_nx   = 1'b0;
                  state_nx = IDLE;
               end
            end else if (tick) begin
               if (s == 4'(STOP_MID)) begin
                  s_nx = '0;
                  if (rx_sync) begin
                     data_nx  = shreg;
                     valid_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
                     perr_nx  = ^{shreg, par_bit};
`endif
                     state_nx = IDLE;
                  end else begin
                     ferr_nx = 1'b1;
                     brk_nx  = 1'b1;
                  end
               end else begin
                  s_nx = s + 4'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: the receive end of the team's 8N1 UART link, listening to the line driven by our transmitter. Oversamples the asynchronous `rx` line at 16× the baud rate using an internal tick generator, rejects start-bit glitches and samples each bit at its midpoint. Delivers each byte as a one-cycle valid strobe and flags a bad stop bit.

## Interface
- `DATA_BITS`, 8, data bits per frame, sent LSB first
- `BAUD_RATE`, 9600, line rate in bits/s
- `CLOCK_RATE`, 100_000_000, `clk` frequency in Hz
- `clk` input 1, system clock; all logic on its rising edge
- `reset` input 1, asynchronous, active-high reset
- `rx` input 1, serial line, asynchronous to `clk`, idles high
- `rx_data` output DATA_BITS, last received byte, held until the next frame completes
- `rx_valid` output 1, one-cycle pulse: `rx_data` holds a good frame
- `frame_err` output 1, one-cycle pulse: stop bit sampled low
- `parity_err` output 1, one-cycle pulse: parity mismatch (see Configuration)
- `busy` output 1, high while a frame is in progress (any state except IDLE)

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1 so reset cannot produce a false start.
- Tick generator: free-running counter with DIV = CLOCK_RATE/(BAUD_RATE*16), integer, truncated (651 at defaults). Emits a 1-cycle `tick` when the count reaches DIV-1, then wraps to 0.
- Counter widths:
  - `s`: 4-bit tick counter.
  - `n`: $clog2(DATA_BITS) bit-index counter.
  - Shift register: DATA_BITS wide.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: synced `rx`==0 → START, `s`=0. No tick is required.
  - START: on each tick, if `s`==7, check synced `rx`. If 0 → DATA, `s`=0, `n`=0. If 1 → IDLE (glitch rejected, no output). Otherwise `s`++.
  - DATA: on the tick where `s`==15, shift synced `rx` in at the MSB and shift right (LSB-first assembly), `s`=0. If `n`==DATA_BITS-1 → PARITY or STOP, else `n`++.
  - PARITY: on the tick where `s`==15, capture the parity bit, `s`=0 → STOP.
  - STOP: on the tick where `s`==15:
    - `rx`==1: load `rx_data`, pulse `rx_valid` (and `parity_err` on mismatch) → IDLE.
    - `rx`==0: pulse `frame_err`, leave `rx_data` unchanged, remain in STOP until synced `rx`==1, then IDLE (a break does not retrigger).
- `rx_valid` and `frame_err` are never asserted in the same cycle.
- A reset mid-frame aborts the frame. The partial byte is discarded.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - FSM in IDLE; tick counter, `s` and `n` all 0.
- Synchronizer latency: 2 clocks. Start detection adds up to 1 clock.
- Bit sampling: start midpoint 8 ticks after detection; each following bit 16 ticks after the previous sample. Tick phase quantization gives up to DIV-1 clocks of skew.
- `rx_valid`, `frame_err` and `parity_err` assert on the clock after the stop-bit sample tick and last exactly 1 cycle.
- The next falling edge is accepted as early as the cycle after return to IDLE, so back-to-back frames have no gap requirement.
- `busy` rises 1 clock after the synced start edge and falls with the `rx_valid` pulse.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in and the frame is 1+DATA_BITS+1+1 bits.
  - Even parity is used: XOR of the data bits and the parity bit must be 0.
  - On mismatch, `parity_err` pulses together with `rx_valid`; the data is still delivered.
- Not defined:
  - No PARITY state; frame is 1+DATA_BITS+1 bits.
  - `parity_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - `OVERSAMPLING`=16.
  - Divisor-computing constant function.
  - `STOP_MID`=15, `START_MID`=7.
- Sub-module `uart_rx_tick_gen` (params CLOCK_RATE, BAUD_RATE; ports `clk`, `reset`, `tick`). It is a single-cycle enable, not a toggled clock.
- The benches use CLOCK_RATE=1_536_000 and BAUD_RATE=9600 (DIV=10) for speed.

## Test plan
- Send frame 0x55, then 0xA3 back-to-back with no idle gap → two `rx_valid` pulses with `rx_data`=0x55 then 0xA3; `frame_err` stays 0.
- Pulse `rx` low for 4 ticks, then high → `busy` pulses and returns to 0; no `rx_valid` or `frame_err`; the next clean 0x3C is received correctly.
- Send 0x00 with the stop bit held low, line low for 40 ticks, then release → exactly one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, no retrigger during the low period.
- Assert `reset` during data bit 4 of 0xFF, release, then send 0x81 → all outputs 0 during reset; next `rx_valid` carries 0x81.
- With `UART_RX_PARITY_EN`, send 0x07 with parity 1, then 0x07 with parity 0 → first frame: `rx_valid` only; second frame: `rx_valid` together with `parity_err`.
- Sweep the line clock ±3% against the nominal baud on 0xC6 → `rx_data`=0xC6 every time.
